ahb_ecap: RTL and testbench

AHB-Lite slave input-capture unit, the measuring counterpart of the team's AHB PWM generator. It timestamps edges of one external PWM-like input. It reports period (rising-to-rising) and active time (rising-to-falling) in HCLK cycles through memory-mapped registers, with a new-data/overrun/timeout status and an interrupt. It sits on the same AHB peripheral bus as the PWM block and can loop back a pwm_out pin for self-test.

---
 rtl/ahb_ecap.sv | 244 ++++++++++++++++++++++++
 tb/tb_ahb_ecap.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_ecap.sv
// ahb_ecap -- AHB-Lite input-capture unit.
//
// Timestamps the edges of one asynchronous PWM-like input and reports the
// period (rising-to-rising) and active time (rising-to-falling) in HCLK
// cycles. Sits on the same AHB peripheral bus as the PWM generator and can
// measure a looped-back pwm_out pin for self-test.
//
// Ports:
//   HCLK, HRESETn        clock, synchronous active-low reset
//   HSEL, HADDR, HTRANS,
//   HSIZE, HWRITE,
//   HWDATA, HREADY       AHB-Lite slave inputs
//   HREADYOUT, HRDATA,
//   HRESP                AHB-Lite slave outputs (zero wait states, OKAY only)
//   cap_in               asynchronous capture input
//   irq                  registered level interrupt
//
// Registers (word offsets):
//   0x00 CTRL   RW  bit0 EN, bit1 POL, bit2 IE_CAP, bit3 IE_TO
//   0x04 STATUS W1C bit0 VALID, bit1 OVR, bit2 TO (cleared via byte lane 0)
//   0x08 PERIOD RO
//   0x0C HIGH   RO
module ahb_ecap #(
  parameter logic [31:0] TIMEOUT_CYC = 32'h00FF_FFFF
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [15:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        HRESP,
  input  logic        cap_in,
  output logic        irq
);

  localparam logic [13:0] ADDR_CTRL   = 14'h0000;
  localparam logic [13:0] ADDR_STATUS = 14'h0001;
  localparam logic [13:0] ADDR_PERIOD = 14'h0002;
  localparam logic [13:0] ADDR_HIGH   = 14'h0003;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_FALL = 2'd1,
    WAIT_RISE = 2'd2
  } capState_e;

  // Byte lanes touched by a transfer, same decode as the PWM block.
  function automatic logic [3:0] byteStrobes(input logic [1:0] addrLo,
                                             input logic [2:0] size);
    logic [3:0] strb;
    case (size)
      3'b000:  strb = 4'b0001 << addrLo;
      3'b001:  strb = addrLo[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

  // Data-phase state captured from the address phase
  logic        dpValid_q;
  logic        dpWrite_q;
  logic [13:0] dpAddr_q;
  logic [3:0]  dpStrb_q;

  // Control / status / results
  logic [3:0]  ctrl_q, ctrl_d;
  logic        valid_q, valid_d;
  logic        ovr_q, ovr_d;
  logic        to_q, to_d;
  logic [31:0] period_q, period_d;
  logic [31:0] high_q, high_d;
  logic [31:0] highTmp_q, highTmp_d;
  logic [31:0] cnt_q, cnt_d;
  logic        irq_q, irq_d;
  capState_e   state_q, state_d;

  // Input path
  logic        sync1_q, sync2_q, prev_q;
  logic        capLevel, capRise, capFall;

  logic        addrPhase;
  logic        ctrlWrite;
  logic [2:0]  statusClr;
  logic [31:0] cntInc;
  logic        ctrlEn, ctrlPol, ctrlIeCap, ctrlIeTo;

  assign ctrlEn    = ctrl_q[0];
  assign ctrlPol   = ctrl_q[1];
  assign ctrlIeCap = ctrl_q[2];
  assign ctrlIeTo  = ctrl_q[3];

  assign addrPhase = HSEL & HTRANS[1] & HREADY;

  // Polarity is applied after the synchronizer so the edge detector always
  // sees the "active" sense; with POL=1 the low time becomes HIGH.
  assign capLevel = sync2_q ^ ctrlPol;
  assign capRise  = capLevel & ~prev_q;
  assign capFall  = ~capLevel & prev_q;

  // Only byte lane 0 carries meaningful CTRL/STATUS bits.
  assign ctrlWrite = dpValid_q & dpWrite_q & (dpAddr_q == ADDR_CTRL) & dpStrb_q[0];
  assign statusClr = (dpValid_q & dpWrite_q & (dpAddr_q == ADDR_STATUS) & dpStrb_q[0])
                     ? HWDATA[2:0] : 3'b000;

  assign cntInc = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;

  // Address-phase capture for the following data phase
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      dpValid_q <= 1'b0;
      dpWrite_q <= 1'b0;
      dpAddr_q  <= '0;
      dpStrb_q  <= '0;
    end else begin
      dpValid_q <= addrPhase;
      if (addrPhase) begin
        dpWrite_q <= HWRITE;
        dpAddr_q  <= HADDR[15:2];
        dpStrb_q  <= byteStrobes(HADDR[1:0], HSIZE);
      end
    end
  end

  // Next-state logic: capture FSM, counter, result and status registers.
  // A hardware set of a status flag overrides a simultaneous W1C.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cntInc;
    highTmp_d = highTmp_q;
    period_d  = period_q;
    high_d    = high_q;
    ctrl_d    = ctrlWrite ? HWDATA[3:0] : ctrl_q;
    valid_d   = valid_q & ~statusClr[0];
    ovr_d     = ovr_q & ~statusClr[1];
    to_d      = to_q & ~statusClr[2];

    if (!ctrlEn) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (capRise) begin
            state_d = WAIT_FALL;
            cnt_d   = 32'd1;
          end
        end
        WAIT_FALL: begin
          if (capFall) begin
            highTmp_d = cnt_q;
            state_d   = WAIT_RISE;
          end else if (cnt_q == TIMEOUT_CYC) begin
            to_d    = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        WAIT_RISE: begin
          // The closing rise also opens the next measurement.
          if (capRise) begin
            period_d = cnt_q;
            high_d   = highTmp_q;
            if (valid_q) ovr_d = 1'b1;
            valid_d  = 1'b1;
            cnt_d    = 32'd1;
            state_d  = WAIT_FALL;
          end else if (cnt_q == TIMEOUT_CYC) begin
            to_d    = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    irq_d = (valid_q & ctrlIeCap) | (to_q & ctrlIeTo);
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      prev_q    <= 1'b0;
      ctrl_q    <= '0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      highTmp_q <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
      to_q      <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      sync1_q   <= cap_in;
      sync2_q   <= sync1_q;
      prev_q    <= capLevel;
      ctrl_q    <= ctrl_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      highTmp_q <= highTmp_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
      to_q      <= to_d;
      irq_q     <= irq_d;
    end
  end

  // Read mux, driven only during a read data phase
  always_comb begin
    HRDATA = '0;
    if (dpValid_q && !dpWrite_q) begin
      case (dpAddr_q)
        ADDR_CTRL:   HRDATA = {28'd0, ctrl_q};
        ADDR_STATUS: HRDATA = {29'd0, to_q, ovr_q, valid_q};
        ADDR_PERIOD: HRDATA = period_q;
        ADDR_HIGH:   HRDATA = high_q;
        default:     HRDATA = '0;
      endcase
    end
  end

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign irq       = irq_q;

  // Bus bits this block has no use for
  logic unusedBits;
  assign unusedBits = ^{HTRANS[0], HWDATA[31:4], dpStrb_q[3:1]};

endmodule

// File: tb/tb_ahb_ecap.sv
// tb_ahb_ecap -- directed testbench for ahb_ecap.
//
// Drives AHB transfers and the capture pin on negative clock edges and
// compares register/interrupt values against hand-computed constants.
module tb_ahb_ecap;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic [15:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;
  logic        cap_in;
  logic        irq;

  int checks = 0;
  int errors = 0;

  localparam logic [15:0] A_CTRL   = 16'h0000;
  localparam logic [15:0] A_STATUS = 16'h0004;
  localparam logic [15:0] A_PERIOD = 16'h0008;
  localparam logic [15:0] A_HIGH   = 16'h000C;

  ahb_ecap #(.TIMEOUT_CYC(32'd1000)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HSIZE     (HSIZE),
    .HWRITE    (HWRITE),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HREADYOUT (HREADYOUT),
    .HRDATA    (HRDATA),
    .HRESP     (HRESP),
    .cap_in    (cap_in),
    .irq       (irq)
  );

  always #5 HCLK = ~HCLK;

  task automatic tick(input int n);
    repeat (n) @(negedge HCLK);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Hold the capture pin at a level for a number of cycles
  task automatic applyStimulus(input logic level, input int cycles);
    cap_in = level;
    tick(cycles);
  endtask

  task automatic ahbWrite(input logic [15:0] addr, input logic [31:0] data,
                          input logic [2:0] size);
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HADDR  = addr;
    HWRITE = 1'b1;
    HSIZE  = size;
    tick(1);
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
    HWDATA = data;
    tick(1);
  endtask

  task automatic ahbRead(input logic [15:0] addr, output logic [31:0] data);
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HADDR  = addr;
    HWRITE = 1'b0;
    HSIZE  = 3'b010;
    tick(1);
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    data   = HRDATA;
  endtask

  task automatic readCheck(input string tag, input logic [15:0] addr,
                           input logic [31:0] expected);
    logic [31:0] rd;
    ahbRead(addr, rd);
    checkOutput(tag, rd, expected);
  endtask

  initial begin
    HRESETn = 1'b0;
    HSEL    = 1'b0;
    HADDR   = '0;
    HTRANS  = 2'b00;
    HSIZE   = 3'b010;
    HWRITE  = 1'b0;
    HWDATA  = '0;
    HREADY  = 1'b1;
    cap_in  = 1'b0;

    // Reset state
    tick(3);
    checkOutput("reset_irq", {31'd0, irq}, 32'd0);
    checkOutput("reset_hrdata", HRDATA, 32'd0);
    checkOutput("hreadyout", {31'd0, HREADYOUT}, 32'd1);
    checkOutput("hresp", {31'd0, HRESP}, 32'd0);
    HRESETn = 1'b1;
    tick(1);

    // Register readback and byte-lane handling
    ahbWrite(A_CTRL, 32'hFFFF_FFFF, 3'b010);
    readCheck("ctrl_rw", A_CTRL, 32'h0000_000F);
    ahbWrite(16'h0001, 32'h0000_0300, 3'b000);
    readCheck("ctrl_byte1_ignored", A_CTRL, 32'h0000_000F);
    ahbWrite(16'h0000, 32'h0000_0002, 3'b000);
    readCheck("ctrl_byte0", A_CTRL, 32'h0000_0002);
    readCheck("status_reset", A_STATUS, 32'd0);
    readCheck("period_reset", A_PERIOD, 32'd0);
    readCheck("high_reset", A_HIGH, 32'd0);
    readCheck("offset10", 16'h0010, 32'd0);

    // Basic capture: 30 high, 70 low
    ahbWrite(A_CTRL, 32'h0, 3'b010);
    ahbWrite(A_CTRL, 32'h5, 3'b010);
    applyStimulus(1'b1, 30);
    applyStimulus(1'b0, 70);
    applyStimulus(1'b1, 3);
    checkOutput("irq_same_cycle_as_valid", {31'd0, irq}, 32'd0);
    tick(1);
    checkOutput("irq_after_valid", {31'd0, irq}, 32'd1);
    readCheck("basic_status", A_STATUS, 32'h1);
    readCheck("basic_period", A_PERIOD, 32'd100);
    readCheck("basic_high", A_HIGH, 32'd30);

    // Overrun, lane-gated W1C and full W1C
    applyStimulus(1'b0, 20);
    applyStimulus(1'b1, 4);
    readCheck("overrun_status", A_STATUS, 32'h3);
    ahbWrite(16'h0005, 32'hFFFF_FFFF, 3'b000);
    readCheck("w1c_wrong_lane", A_STATUS, 32'h3);
    ahbWrite(A_STATUS, 32'h3, 3'b010);
    readCheck("w1c_clear", A_STATUS, 32'h0);
    checkOutput("irq_after_clear", {31'd0, irq}, 32'd0);

    // W1C colliding with a capture: the set wins
    applyStimulus(1'b0, 20);
    applyStimulus(1'b1, 4);
    readCheck("valid_again", A_STATUS, 32'h1);
    applyStimulus(1'b0, 20);
    cap_in = 1'b1;
    tick(1);
    ahbWrite(A_STATUS, 32'h1, 3'b010);
    readCheck("set_beats_w1c", A_STATUS, 32'h3);

    // Inverted polarity: low time is reported as HIGH
    ahbWrite(A_CTRL, 32'h0, 3'b010);
    ahbWrite(A_STATUS, 32'h7, 3'b010);
    ahbWrite(A_CTRL, 32'h2, 3'b010);
    applyStimulus(1'b1, 10);
    ahbWrite(A_CTRL, 32'h7, 3'b010);
    applyStimulus(1'b0, 70);
    applyStimulus(1'b1, 30);
    applyStimulus(1'b0, 3);
    readCheck("pol_period", A_PERIOD, 32'd100);
    readCheck("pol_high", A_HIGH, 32'd70);
    readCheck("pol_status", A_STATUS, 32'h1);

    // Timeout after 1000 cycles stuck high
    ahbWrite(A_CTRL, 32'h0, 3'b010);
    ahbWrite(A_STATUS, 32'h7, 3'b010);
    ahbWrite(A_CTRL, 32'h9, 3'b010);
    applyStimulus(1'b1, 1003);
    checkOutput("irq_before_timeout", {31'd0, irq}, 32'd0);
    tick(1);
    checkOutput("irq_timeout", {31'd0, irq}, 32'd1);
    readCheck("timeout_status", A_STATUS, 32'h4);
    readCheck("timeout_period_kept", A_PERIOD, 32'd100);
    applyStimulus(1'b0, 10);
    applyStimulus(1'b1, 30);
    applyStimulus(1'b0, 70);
    applyStimulus(1'b1, 3);
    readCheck("after_timeout_status", A_STATUS, 32'h5);
    readCheck("after_timeout_period", A_PERIOD, 32'd100);
    readCheck("after_timeout_high", A_HIGH, 32'd30);

    // Disable mid-measurement; re-enable needs a full rise-fall-rise
    ahbWrite(A_STATUS, 32'h7, 3'b010);
    ahbWrite(A_CTRL, 32'h1, 3'b010);
    applyStimulus(1'b0, 30);
    ahbWrite(A_CTRL, 32'h0, 3'b010);
    applyStimulus(1'b1, 10);
    applyStimulus(1'b0, 10);
    ahbWrite(A_CTRL, 32'h1, 3'b010);
    applyStimulus(1'b1, 25);
    applyStimulus(1'b0, 35);
    readCheck("no_partial_after_enable", A_STATUS, 32'h0);
    applyStimulus(1'b0, 19);
    applyStimulus(1'b1, 3);
    readCheck("reenable_status", A_STATUS, 32'h1);
    readCheck("reenable_period", A_PERIOD, 32'd80);
    readCheck("reenable_high", A_HIGH, 32'd25);

    // Reset in the middle of a measurement
    HRESETn = 1'b0;
    tick(1);
    HRESETn = 1'b1;
    checkOutput("midreset_irq", {31'd0, irq}, 32'd0);
    readCheck("midreset_ctrl", A_CTRL, 32'h0);
    readCheck("midreset_status", A_STATUS, 32'h0);
    readCheck("midreset_period", A_PERIOD, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
